// File: rtl/clock_pkg.sv
// Shared constants and BCD helpers for the HH:MM clock controller.
package clock_pkg;

  localparam int DIGIT_W       = 4;
  localparam int HOURS_LIMIT   = 24;
  localparam int MINUTES_LIMIT = 60;
  localparam int SECONDS_LIMIT = 60;

  localparam int DEF_TICK_DIV  = 100000000;
  localparam int DEF_BLINK_DIV = 25000000;

  localparam logic [1:0] MODE_RUN     = 2'd0;
  localparam logic [1:0] MODE_SET_HR  = 2'd1;
  localparam logic [1:0] MODE_SET_MIN = 2'd2;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Two-digit BCD increment that wraps to 00 after limit-1.
  function automatic logic [2*DIGIT_W-1:0] bcd_inc(input logic [2*DIGIT_W-1:0] v,
                                                   input int limit);
    digit_t tens;
    digit_t ones;
    tens = v[2*DIGIT_W-1:DIGIT_W];
    ones = v[DIGIT_W-1:0];
    if ((int'(tens) * 10 + int'(ones)) == (limit - 1))
      return '0;
    else if (ones == digit_t'(9))
      return {digit_t'(tens + digit_t'(1)), digit_t'(0)};
    else
      return {tens, digit_t'(ones + digit_t'(1))};
  endfunction

endpackage

// File: rtl/clock_btn_edge.sv
// Two-flop synchronizer plus rising-edge detector; pulse is high for one
// cycle after the second sync flop first sees the button high.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/clock_ctrl.sv
// 24h HH:MM clock with RUN / SET_HR / SET_MIN modes, two pushbuttons and
// blinking decimal points marking the field being set.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int BLINK_DIV = DEF_BLINK_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_mode,
  input  logic               btn_inc,
  output logic [DIGIT_W-1:0] val3,
  output logic [DIGIT_W-1:0] val2,
  output logic [DIGIT_W-1:0] val1,
  output logic [DIGIT_W-1:0] val0,
  output logic               dot3,
  output logic               dot2,
  output logic               dot1,
  output logic               dot0,
  output logic [1:0]         mode,
  output logic               sec_tick
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [5:0]    SEC_MAX   = 6'(SECONDS_LIMIT - 1);
  localparam logic [7:0]    MIN_MAX   = 8'h59;

  logic          mode_pulse;
  logic          inc_pulse;
  logic [1:0]    state;
  logic [TW-1:0] presc;
  logic [5:0]    secs;
  digit_t        h_t, h_o, m_t, m_o;
  logic [BW-1:0] blink_cnt;
  logic          blink;
  logic          run;
  logic          tick;

  btn_edge u_mode_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_mode),
    .pulse (mode_pulse)
  );

  btn_edge u_inc_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_inc),
    .pulse (inc_pulse)
  );

  assign run  = (state == MODE_RUN);
  // A mode edge leaving RUN swallows a coincident tick entirely.
  assign tick = run && (presc == TICK_MAX) && !mode_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MODE_RUN;
      presc <= '0;
      secs  <= '0;
      h_t   <= '0;
      h_o   <= '0;
      m_t   <= '0;
      m_o   <= '0;
    end else if (mode_pulse) begin
      presc <= '0;
      secs  <= '0;
      case (state)
        MODE_RUN:    state <= MODE_SET_HR;
        MODE_SET_HR: state <= MODE_SET_MIN;
        default:     state <= MODE_RUN;
      endcase
    end else if (run) begin
      if (tick) begin
        presc <= '0;
        if (secs == SEC_MAX) begin
          secs       <= '0;
          {m_t, m_o} <= bcd_inc({m_t, m_o}, MINUTES_LIMIT);
          if ({m_t, m_o} == MIN_MAX)
            {h_t, h_o} <= bcd_inc({h_t, h_o}, HOURS_LIMIT);
        end else begin
          secs <= secs + 6'd1;
        end
      end else begin
        presc <= presc + TW'(1);
      end
    end else if (inc_pulse) begin
      if (state == MODE_SET_HR)
        {h_t, h_o} <= bcd_inc({h_t, h_o}, HOURS_LIMIT);
      else
        {m_t, m_o} <= bcd_inc({m_t, m_o}, MINUTES_LIMIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign val3     = h_t;
  assign val2     = h_o;
  assign val1     = m_t;
  assign val0     = m_o;
  assign mode     = state;
  assign sec_tick = tick;

  assign dot3 = (state == MODE_SET_HR) & blink;
  assign dot2 = run ? secs[0] : ((state == MODE_SET_HR) & blink);
  assign dot1 = (state == MODE_SET_MIN) & blink;
  assign dot0 = (state == MODE_SET_MIN) & blink;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with TICK_DIV=4, BLINK_DIV=2.
module tb_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] val3, val2, val1, val0;
  logic       dot3, dot2, dot1, dot0;
  logic [1:0] mode;
  logic       sec_tick;

  int n_checks = 0;
  int n_fail = 0;
  int cyc;

  clock_ctrl #(.TICK_DIV(4), .BLINK_DIV(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .val3     (val3),
    .val2     (val2),
    .val1     (val1),
    .val0     (val0),
    .dot3     (dot3),
    .dot2     (dot2),
    .dot1     (dot1),
    .dot0     (dot0),
    .mode     (mode),
    .sec_tick (sec_tick)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the blink phase is (cyc/2)%2.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  wire [15:0] vals = {val3, val2, val1, val0};
  wire [3:0]  dots = {dot3, dot2, dot1, dot0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    repeat (3) step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) step();
  endtask

  task automatic press_inc(input int k);
    repeat (k) press(1'b0, 1'b1);
  endtask

  function automatic logic blink_exp();
    return ((cyc / 2) % 2) == 1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b;

    repeat (2) step();
    chk("reset_vals", vals, 16'h0000);
    chk("reset_mode", mode, 2'd0);
    chk("reset_dots", dots, 4'b0000);
    chk("reset_tick", sec_tick, 1'b0);

    #3 rst_n = 1'b1;
    step(); step();
    chk("tick_early", sec_tick, 1'b0);
    step();
    chk("tick_first", sec_tick, 1'b1);
    chk("vals_at_tick", vals, 16'h0000);
    step();
    chk("tick_one_cycle", sec_tick, 1'b0);
    chk("colon_sec1", dots, 4'b0100);
    repeat (4) step();
    chk("colon_sec2", dots, 4'b0000);

    // Inc ignored in RUN
    press(1'b0, 1'b1);
    chk("inc_in_run", vals, 16'h0000);

    press(1'b1, 1'b0);
    chk("mode_set_hr", mode, 2'd1);
    press_inc(23);
    chk("hours_23", vals, 16'h2300);
    press(1'b1, 1'b0);
    chk("mode_set_min", mode, 2'd2);
    press_inc(59);
    chk("mins_59", vals, 16'h2359);

    btn_mode = 1'b1;
    repeat (3) step();
    btn_mode = 1'b0;
    chk("mode_run", mode, 2'd0);
    repeat (239) step();
    chk("tick_235959", sec_tick, 1'b1);
    chk("vals_235959", vals, 16'h2359);
    chk("colon_59", dots, 4'b0100);
    step();
    chk("wrap_vals", vals, 16'h0000);
    chk("wrap_secs0", dots, 4'b0000);

    btn_mode = 1'b1;
    step(); step();
    chk("mode_not_yet", mode, 2'd0);
    step();
    chk("mode_3rd_edge", mode, 2'd1);
    btn_mode = 1'b0;
    repeat (3) step();
    press_inc(5);
    chk("hours_05", vals, 16'h0500);
    for (int k = 0; k < 4; k++) begin
      step();
      b = blink_exp();
      chk("blink_set_hr", dots, {b, b, 2'b00});
      chk("no_tick_set", sec_tick, 1'b0);
    end

    press(1'b1, 1'b0);
    chk("mode_set_min2", mode, 2'd2);
    b = blink_exp();
    chk("blink_set_min", dots, {2'b00, b, b});
    press_inc(59);
    chk("mins_0559", vals, 16'h0559);
    press(1'b0, 1'b1);
    chk("min_wrap_nocarry", vals, 16'h0500);

    btn_mode = 1'b1;
    repeat (3) step();
    btn_mode = 1'b0;
    chk("mode_run2", mode, 2'd0);
    chk("restart_t0", sec_tick, 1'b0);
    step();
    chk("restart_t1", sec_tick, 1'b0);
    step();
    chk("restart_t2", sec_tick, 1'b0);
    step();
    chk("restart_t3", sec_tick, 1'b1);
    step();
    chk("restart_colon", dots, 4'b0100);

    press(1'b1, 1'b0);
    chk("mode_set_hr2", mode, 2'd1);
    press(1'b1, 1'b1);
    chk("both_mode", mode, 2'd2);
    chk("both_vals", vals, 16'h0500);
    btn_inc = 1'b1;
    repeat (20) step();
    btn_inc = 1'b0;
    repeat (3) step();
    chk("held_single", vals, 16'h0501);

    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press_inc(7);
    press(1'b1, 1'b0);
    press_inc(33);
    chk("pre_reset_vals", vals, 16'h1234);
    chk("pre_reset_mode", mode, 2'd2);

    #2 rst_n = 1'b0;
    #1;
    chk("async_vals", vals, 16'h0000);
    chk("async_mode", mode, 2'd0);
    chk("async_dots", dots, 4'b0000);
    chk("async_tick", sec_tick, 1'b0);
    repeat (2) step();
    #3 rst_n = 1'b1;
    step(); step();
    chk("resume_t2", sec_tick, 1'b0);
    step();
    chk("resume_t3", sec_tick, 1'b1);
    step();
    chk("resume_colon", dots, 4'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, meaning clk cycles per one-second tick (>=2).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, meaning clk cycles per blink-phase toggle (>=1).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port btn_mode  input  1  asynchronous mode pushbutton, active-high.
REQ-006 SHALL have port btn_inc  input  1  asynchronous increment pushbutton, active-high.
REQ-007 SHALL have ports val3, val2, val1, val0  output  4 each  BCD digits to the seven-segment driver: hour tens, hour ones, minute tens, minute ones.
REQ-008 SHALL have ports dot3, dot2, dot1, dot0  output  1 each  decimal-point requests to the driver, active-high.
REQ-009 SHALL have port mode  output  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN.
REQ-010 SHALL have port sec_tick  output  1  one-cycle pulse on each one-second tick in RUN.

Function
REQ-011 Each button SHALL pass through a two-flop synchronizer plus rising-edge detector; the action SHALL take effect on outputs at the 3rd rising clk edge after the input first goes high.
REQ-012 A held button SHALL produce exactly one action; no auto-repeat.
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 in RUN and wrap; sec_tick SHALL be high for the cycle the count equals TICK_DIV-1.
REQ-014 On each tick, seconds (0..59, internal) SHALL increment; 59->0 SHALL carry to minutes; minutes 59->00 SHALL carry to hours; hours 23->00 SHALL wrap with no further effect.
REQ-015 FSM SHALL advance on a btn_mode edge: RUN->SET_HR->SET_MIN->RUN.
REQ-016 In SET_HR and SET_MIN, the prescaler and seconds SHALL be held at 0 and sec_tick SHALL stay 0.
REQ-017 A btn_inc edge in SET_HR SHALL increment hours modulo 24 (23->00).
REQ-018 A btn_inc edge in SET_MIN SHALL increment minutes modulo 60 with no carry into hours.
REQ-019 A btn_inc edge in RUN SHALL be ignored.
REQ-020 When btn_mode and btn_inc edges coincide, the mode edge SHALL be applied and the inc edge discarded.
REQ-021 When a RUN->SET_HR transition coincides with a tick, the tick SHALL be discarded: no seconds/minute carry and no sec_tick pulse.
REQ-022 On SET_MIN->RUN, prescaler and seconds SHALL restart from 0.
REQ-023 Time SHALL be stored as four BCD digit registers; val outputs SHALL be those registers directly, with no combinational conversion, and always in 0..9.
REQ-024 Blink phase SHALL toggle every BLINK_DIV cycles in all states.
REQ-025 Dots in RUN SHALL be: dot2 = seconds LSB (colon), others 0.
REQ-026 Dots in SET_HR SHALL be: dot3 = dot2 = blink phase, others 0.
REQ-027 Dots in SET_MIN SHALL be: dot1 = dot0 = blink phase, others 0.

Reset
REQ-028 While rst_n=0, the block SHALL force time 00:00:00, mode RUN, prescaler 0, blink phase 0, synchronizer/edge flops 0, sec_tick 0 and all dots 0.
REQ-029 Assertion mid-operation, including mid-SET, SHALL take effect immediately without waiting for clk.
REQ-030 The block SHALL resume RUN counting from 0 on the first clk edge after deassertion.

Structure
REQ-031 Package clock_pkg SHALL hold the state encoding (RUN/SET_HR/SET_MIN), the BCD digit width, the limits 24/60 and the default TICK_DIV/BLINK_DIV.
REQ-032 Sub-module btn_edge (synchronizer plus rising-edge pulse) SHALL be instantiated once per button.
REQ-033 Outputs SHALL connect directly to the quad seven-segment driver's val/dot inputs.

Verification (TICK_DIV=4, BLINK_DIV=2)
REQ-034 Bench SHALL cover: release reset, run 4 cycles -> one sec_tick pulse, val=0,0,0,0, dot2 toggles per tick.
REQ-035 Bench SHALL cover: force time 23:59:59 in RUN, one tick -> val=0,0,0,0, seconds 0.
REQ-036 Bench SHALL cover: btn_mode pulse -> mode=1 at 3rd edge; 5 btn_inc pulses -> val3,val2 = 0,5; dot3/dot2 blink every 2 cycles; val1,val0 unchanged.
REQ-037 Bench SHALL cover: in SET_MIN at minute 59, btn_inc -> minutes 00, hours unchanged; btn_mode -> mode=0, first sec_tick exactly 4 cycles later.
REQ-038 Bench SHALL cover: btn_mode and btn_inc rising together in SET_HR -> mode=2, hours unchanged; btn_inc held 20 cycles -> single increment.
REQ-039 Bench SHALL cover: rst_n low between clk edges during SET_MIN at 12:34 -> outputs immediately 0,0,0,0, mode=0, dots 0.
